// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by the DMA and its device-side memories.
package tlul_pkg;

  // A-channel opcodes
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  // D-channel opcodes
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_dma_sram.sv
// TL-UL device-side word memory targeted by student_dma.
// Serves Get / PutFullData (and PutPartialData when STUDENT_DMA_SRAM_PARTIAL_EN
// is defined) with one-cycle latency, one outstanding response, and a
// saturating count of error responses.
module student_dma_sram
  import tlul_pkg::*;
#(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AW    = $clog2(Depth)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  tl_h2d_t     tl_i,
  output tl_d2h_t     tl_o,
  output logic        busy_o,
  output logic [15:0] err_cnt_o
);

  typedef enum logic [0:0] {StIdle, StRsp} state_e;

  state_e state_q, state_d;

`ifdef STUDENT_DMA_SRAM_PARTIAL_EN
  localparam bit PartialEn = 1'b1;
`else
  localparam bit PartialEn = 1'b0;
`endif

  logic [31:0] mem [Depth];

  logic          a_ready;
  logic          accept;
  logic          drain;
  logic [AW-1:0] idx;
  logic          is_get, is_pfull, is_ppart;
  logic          range_ok;
  logic          req_err;
  logic          we;
  logic [3:0]    wmask;
  logic [31:0]   rdata;

  logic [2:0]  d_opcode_q;
  logic        d_error_q;
  logic [31:0] d_data_q;
  logic [7:0]  d_source_q;
  logic [1:0]  d_size_q;
  logic [15:0] err_cnt_q;

  // a_param carries no meaning for this target
  logic unused_a_param;
  assign unused_a_param = ^tl_i.a_param;

  // Request decode and ordered legality checks
  always_comb begin
    a_ready  = (state_q == StIdle) || tl_i.d_ready;
    accept   = tl_i.a_valid && a_ready;
    drain    = (state_q == StRsp) && tl_i.d_ready;
    idx      = tl_i.a_address[AW+1:2];
    is_get   = (tl_i.a_opcode == Get);
    is_pfull = (tl_i.a_opcode == PutFullData);
    is_ppart = (tl_i.a_opcode == PutPartialData);
    range_ok = ((tl_i.a_address >> (AW + 2)) == 32'd0);

    req_err = 1'b0;
    if (!(is_get || is_pfull || is_ppart)) begin
      req_err = 1'b1;
    end else if ((tl_i.a_address[1:0] != 2'b00) || (tl_i.a_size != 2'd2)) begin
      req_err = 1'b1;
    end else if (!range_ok) begin
      req_err = 1'b1;
    end else if (is_pfull && (tl_i.a_mask != 4'hF)) begin
      req_err = 1'b1;
    end else if (is_ppart && !PartialEn) begin
      req_err = 1'b1;
    end

    wmask = is_pfull ? 4'hF : tl_i.a_mask;
    // rst_ni gate: an accept edge that coincides with reset must not write
    we    = accept && !req_err && !is_get && rst_ni;
    rdata = mem[idx];
  end

  // Byte-masked storage; contents are deliberately not reset
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we && wmask[b]) begin
        mem[idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
      end
    end
  end

  // FSM next-state: a drain with a fresh accept stays in StRsp
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StRsp;
      StRsp:  if (drain && !accept) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // D-channel response capture; held unchanged while stalled since a_ready is low
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_opcode_q <= AccessAck;
      d_error_q  <= 1'b0;
      d_data_q   <= 32'd0;
      d_source_q <= 8'd0;
      d_size_q   <= 2'd0;
    end else if (accept) begin
      d_opcode_q <= is_get ? AccessAckData : AccessAck;
      d_error_q  <= req_err;
      d_data_q   <= (is_get && !req_err) ? rdata : 32'd0;
      d_source_q <= tl_i.a_source;
      d_size_q   <= tl_i.a_size;
    end
  end

  // Saturating error-response counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= 16'd0;
    end else if (accept && req_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  // Output assembly
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = (state_q == StRsp);
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_param  = 3'd0;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = a_ready;
    busy_o        = (state_q == StRsp);
    err_cnt_o     = err_cnt_q;
  end

endmodule

// File: doc/student_dma_sram.md
# student_dma_sram

TL-UL device-side word memory that is the write/read target of `student_dma`. It sits on the device side of the bus, downstream of the DMA host port. It serves descriptor fetches (Get) and memset/copy stores (PutFullData, optionally PutPartialData). It holds at most one outstanding response and keeps a saturating error counter for debug.

## Interface
Parameters:
- `Depth`, 1024: number of 32-bit words; must be a power of two, ≥ 4.
- `AW`, `$clog2(Depth)`: word-index width (derived; do not override).

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `tl_i`  in  `tlul_pkg::tl_h2d_t`  request channel A and `d_ready`.
- `tl_o`  out  `tlul_pkg::tl_d2h_t`  response channel D and `a_ready`.
- `busy_o`  out  1  a response is pending (`d_valid` high).
- `err_cnt_o`  out  16  count of error responses issued, saturating at 16'hFFFF.

## Operation
- Word index is `idx = a_address[AW+1:2]`. The address is in range when `a_address[31:AW+2] == 0`.
- FSM states:
  - `IDLE`: no response pending.
  - `RSP`: response held on D.
- Transitions:
  - `IDLE` → `RSP` on A-channel accept.
  - `RSP` → `IDLE` on `d_valid && d_ready` with no new accept in the same cycle.
  - `RSP` → `RSP` on drain plus new accept (back-to-back).
- `a_ready = (state == IDLE) || d_ready`, so one request can be accepted in the same cycle the previous response drains.
- A request is accepted when `a_valid && a_ready`. Checks are applied in this order; the first failing check sets `d_error`:
  - opcode not in {Get, PutFullData, PutPartialData} → error.
  - `a_address[1:0] != 0` or `a_size != 2` → error.
  - address out of range → error.
  - PutFullData with `a_mask != 4'hF` → error.
  - PutPartialData: see Configuration.
- Get with no error: `d_opcode = AccessAckData`, `d_data = mem[idx]` (value before any same-cycle write).
- Put with no error: write the masked bytes of `a_data` into `mem[idx]`; `d_opcode = AccessAck`, `d_data = 0`.
- Any error: no memory write, `d_data = 0`. `d_opcode` is AccessAckData for Get, otherwise AccessAck. `err_cnt_o` increments at acceptance unless already 16'hFFFF.
- `d_source`, `d_size` and `d_param = 0` are captured from the accepted request. `d_sink = 0`.
- Memory contents are not reset; reads before the first write return undefined data.

## Timing
- Reset values: `d_valid = 0`, `d_opcode = AccessAck`, `d_error = 0`, `d_data = 0`, `d_source = 0`, `d_size = 0`, `busy_o = 0`, `err_cnt_o = 0`, state `IDLE`. `a_ready = 1` while in reset.
- Latency: a request accepted at edge N presents `d_valid = 1` from edge N until the edge where `d_ready = 1`, i.e. one-cycle latency. The write lands in memory at edge N.
- D-channel fields stay stable while `d_valid && !d_ready`. `a_ready` is 0 during that stall.
- Throughput: one transaction per cycle while `d_ready` is held high.
- A Get immediately after a Put to the same word returns the new data: the write is visible at N+1 and the next read samples at N+1 or later.
- Reset mid-response drops the pending response. No write occurs for a request whose accept edge coincides with reset assertion.

## Configuration
- `STUDENT_DMA_SRAM_PARTIAL_EN` defined:
  - PutPartialData is accepted with any mask, including 4'h0, which acks without modifying memory.
  - Only bytes with `a_mask[i] = 1` are written.
- Undefined:
  - PutPartialData returns an AccessAck with `d_error = 1`, no write, and increments `err_cnt_o`.
  - PutFullData still requires mask 4'hF.

## Test plan
- Reset, then PutFullData addr 0x10 data 0xDEADBEEF, then Get 0x10 → AccessAck with `d_error = 0`, then AccessAckData with `d_data = 0xDEADBEEF`, each one cycle after accept; `d_source` echoed.
- Back-to-back: `d_ready` held high, 8 PutFullData to 0x0..0x1C, then 8 Gets → `a_ready` stays 1 throughout, 16 responses in 16 cycles, read data matches.
- Stall: Get accepted with `d_ready = 0` for 5 cycles → `d_valid` and `d_data` stable, `a_ready = 0` and `busy_o = 1` throughout; drain → next request accepted in the drain cycle.
- Errors: Get at 0x2 (misaligned), PutFullData with mask 4'h3, Get at address `Depth*4` → three responses with `d_error = 1`, no memory change, `err_cnt_o = 3`.
- PartialData: word 0x20 = 0x11223344, PutPartialData mask 4'b0101 data 0xAABBCCDD → with macro, reads 0x11BB33DD; without macro, `d_error = 1` and reads 0x11223344.
- Reset asserted while `d_valid = 1` → `d_valid` drops immediately, `err_cnt_o = 0`, and a following Get is served normally.
